// File: rtl/demux_flow_ctrl.sv
// demux_flow_ctrl: link-level flow controller for the 1-to-4 demux stage.
// Pops the ingress FIFO head word and steers it, one cycle later, to the
// destination FIFO selected by its top two bits. Tracks per-destination
// occupancy and pauses a destination with high/low threshold hysteresis.
//
// state  | meaning
// -------+----------------------------------------------------------------
// RESET  | just out of reset; everything cleared, moves to INIT
// INIT   | capturing thresholds while init=1; validated on init release
// IDLE   | link up, ingress empty and all destinations drained
// ACTIVE | moving words; pops gated by the pause flag of the head word
// ERROR  | underflow/overflow or bad thresholds; sticky until reset

module demux_flow_ctrl #(
    parameter int WORD_WIDTH = 6,
    parameter int NUM_DEST   = 4,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int THR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [THR_WIDTH-1:0]  cfg_umbral_alto,
    input  logic [THR_WIDTH-1:0]  cfg_umbral_bajo,
    input  logic                  fifo_empty,
    input  logic [WORD_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    input  logic [NUM_DEST-1:0]   dest_pop,
    output logic [WORD_WIDTH-1:0] demux_data_out,
    output logic [NUM_DEST-1:0]   demux_push,
    output logic [NUM_DEST-1:0]   pause,
    output logic [2:0]            estado,
    output logic                  idle_out,
    output logic                  error_out
);

    // Comparison width: one bit wider than both counter and threshold so that
    // count_next can exceed DEPTH (or wrap below zero) without aliasing.
    localparam int CMP_W = ((CNT_WIDTH >= THR_WIDTH) ? CNT_WIDTH : THR_WIDTH) + 1;
    localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t                r_state;
    logic [THR_WIDTH-1:0]  r_alto;
    logic [THR_WIDTH-1:0]  r_bajo;
    logic [CNT_WIDTH-1:0]  r_count [NUM_DEST];
    logic [NUM_DEST-1:0]   r_pause;
    logic [NUM_DEST-1:0]   r_push;
    logic [WORD_WIDTH-1:0] r_data;

    logic [1:0]            w_sel;
    logic                  w_pop;
    logic [NUM_DEST-1:0]   w_push_issue;
    logic [CMP_W-1:0]      w_count_next [NUM_DEST];
    logic [NUM_DEST-1:0]   w_underflow;
    logic [NUM_DEST-1:0]   w_overflow;
    logic [NUM_DEST-1:0]   w_pause_next;
    logic                  w_any_count;
    logic                  w_err;
    logic                  w_cfg_ok;
    logic                  w_track;

    assign w_sel = fifo_data[WORD_WIDTH-1 -: 2];

    // Head-of-line pop: a paused head word blocks every destination.
    assign w_pop = (r_state == ST_ACTIVE) && !fifo_empty && !r_pause[w_sel];

    // Same-cycle push decode feeding the occupancy counters.
    always_comb begin
        w_push_issue = '0;
        if (w_pop) begin
            w_push_issue[w_sel] = 1'b1;
        end
    end

    // Next occupancy, error conditions and hysteresis decision per destination.
    always_comb begin
        w_any_count = 1'b0;
        for (int d = 0; d < NUM_DEST; d++) begin
            w_count_next[d] = CMP_W'(r_count[d]) + CMP_W'(w_push_issue[d])
                            - CMP_W'(dest_pop[d]);
            w_underflow[d]  = dest_pop[d] && (r_count[d] == '0) && !w_push_issue[d];
            w_overflow[d]   = (w_count_next[d] > DEPTH_C);
            if (w_count_next[d] >= CMP_W'(r_alto)) begin
                w_pause_next[d] = 1'b1;
            end else if (w_count_next[d] <= CMP_W'(r_bajo)) begin
                w_pause_next[d] = 1'b0;
            end else begin
                w_pause_next[d] = r_pause[d];
            end
            if (r_count[d] != '0) begin
                w_any_count = 1'b1;
            end
        end
    end

    // Counters keep tracking dest_pop in INIT so a re-init does not lose state.
    assign w_track  = (r_state == ST_INIT) || (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
    assign w_err    = w_track && ((|w_underflow) || (|w_overflow));
    assign w_cfg_ok = (CMP_W'(cfg_umbral_bajo) < CMP_W'(cfg_umbral_alto))
                   && (CMP_W'(cfg_umbral_alto) <= DEPTH_C);

    // Link state machine with registered push/data outputs and threshold capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RESET;
            r_alto  <= '0;
            r_bajo  <= '0;
            r_push  <= '0;
            r_data  <= '0;
        end else begin
            r_push <= w_err ? '0 : w_push_issue;
            if (w_pop) begin
                r_data <= fifo_data;
            end
            case (r_state)
                ST_RESET: begin
                    r_state <= ST_INIT;
                end
                ST_INIT: begin
                    r_alto <= cfg_umbral_alto;
                    r_bajo <= cfg_umbral_bajo;
                    if (w_err) begin
                        r_state <= ST_ERROR;
                    end else if (!init) begin
                        r_state <= w_cfg_ok ? ST_IDLE : ST_ERROR;
                    end
                end
                ST_IDLE: begin
                    if (w_err) begin
                        r_state <= ST_ERROR;
                    end else if (init) begin
                        r_state <= ST_INIT;
                    end else if (!fifo_empty || w_any_count) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_err) begin
                        r_state <= ST_ERROR;
                    end else if (init) begin
                        r_state <= ST_INIT;
                    end else if (fifo_empty && !w_any_count && (r_push == '0)) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_ERROR;
                end
            endcase
        end
    end

    // Occupancy counters and pause flags; frozen on the error edge and in ERROR.
    // Pause is held in INIT because the thresholds are in flux there.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < NUM_DEST; d++) begin
                r_count[d] <= '0;
            end
            r_pause <= '0;
        end else if (w_track && !w_err) begin
            for (int d = 0; d < NUM_DEST; d++) begin
                r_count[d] <= w_count_next[d][CNT_WIDTH-1:0];
            end
            if (r_state != ST_INIT) begin
                r_pause <= w_pause_next;
            end
        end
    end

    assign fifo_pop       = w_pop;
    assign demux_push     = r_push;
    assign demux_data_out = r_data;
    assign pause          = r_pause;
    assign estado         = r_state;
    assign idle_out       = (r_state == ST_IDLE);
    assign error_out      = (r_state == ST_ERROR);

endmodule

// File: doc/demux_flow_ctrl.md
Name: demux_flow_ctrl

Overview:
Flow controller that sequences the 1-to-4 demux stage between the upstream ingress FIFO and four downstream destination FIFOs. Each cycle it pops at most one head word from the ingress FIFO and steers it to the destination selected by the word's top two bits. It tracks the occupancy of every destination FIFO and pauses a destination using high/low threshold hysteresis. The block also owns the link-level state machine RESET/INIT/IDLE/ACTIVE/ERROR.

Parameters:
WORD_WIDTH, 6, ingress word width; bits [WORD_WIDTH-1:WORD_WIDTH-2] select the destination.
NUM_DEST, 4, number of destination FIFOs; fixed at 4 for the 2-bit selector.
DEPTH, 8, capacity of each destination FIFO.
CNT_WIDTH, 4, occupancy counter width; must hold DEPTH.
THR_WIDTH, 4, threshold width.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
init  in  1  request to enter or stay in INIT and (re)load the thresholds.
cfg_umbral_alto  in  THR_WIDTH  high threshold (pause level).
cfg_umbral_bajo  in  THR_WIDTH  low threshold (resume level).
fifo_empty  in  1  ingress FIFO empty.
fifo_data  in  WORD_WIDTH  ingress head word (show-ahead; valid when fifo_empty=0).
fifo_pop  out  1  ingress pop; combinational.
dest_pop  in  NUM_DEST  per-destination pop strobes from the downstream consumers.
demux_data_out  out  WORD_WIDTH  registered word to the destinations.
demux_push  out  NUM_DEST  registered one-hot push.
pause  out  NUM_DEST  registered per-destination pause flags.
estado  out  3  state code: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
idle_out  out  1  high while in IDLE.
error_out  out  1  high while in ERROR.

Behaviour:
- Reset (reset=1 at a clk edge):
  - State goes to RESET.
  - All outputs, the four counters and the stored thresholds clear to 0.
  - Reset overrides everything, including mid-transfer and ERROR.
- RESET: moves to INIT on the first edge with reset=0.
- INIT:
  - Captures cfg_umbral_alto/bajo on every edge while in INIT.
  - Stays while init=1.
  - On init=0: goes to IDLE if the captured bajo < alto <= DEPTH; otherwise goes to ERROR.
  - No pops are issued in INIT.
- IDLE:
  - Goes to ACTIVE when fifo_empty=0 or any counter is non-zero.
  - Stays in IDLE otherwise.
- ACTIVE:
  - Returns to IDLE when fifo_empty=1, all counters are 0 and no push is pending.
- From IDLE or ACTIVE, init=1 goes to INIT. Counters and pause flags are preserved, and dest_pop keeps being counted.
- ERROR:
  - Sticky until reset.
  - fifo_pop=0, demux_push=0, error_out=1.
  - Counters are frozen.
- Pop rule (ACTIVE only):
  - With d = fifo_data[WORD_WIDTH-1:WORD_WIDTH-2], fifo_pop = !fifo_empty && !pause[d].
  - A paused head word blocks all destinations (head-of-line blocking is intended).
- Latency:
  - The edge after fifo_pop=1 sets demux_push = one-hot(d) and demux_data_out = fifo_data.
  - demux_push is otherwise 0. demux_data_out holds its last value.
- Counters, per destination d:
  - count_next = count + push_issue[d] - dest_pop[d], where push_issue is the same-cycle fifo_pop decode.
  - A simultaneous push and pop leaves the count unchanged.
  - No wrap-around is allowed.
- Pause hysteresis (registered, computed from count_next):
  - Set when count_next >= alto.
  - Clear when count_next <= bajo.
  - Hold otherwise.
  - Because the pop check uses the registered pause, a destination is never filled beyond alto.
- Error detection (entered on the next edge from any state except RESET):
  - dest_pop[d]=1 with count[d]=0 and no concurrent push to d (underflow), or
  - count_next > DEPTH (overflow).
- Outputs: idle_out = (estado==IDLE); error_out = (estado==ERROR).

Test Plan:
1. Reset, then init=1 for 2 cycles with alto=6, bajo=2, then init=0 -> estado 0→1→2; idle_out=1; all outputs 0.
2. Ingress holds words 0x05, 0x16, 0x27, 0x38, consumers idle -> fifo_pop on 4 consecutive cycles; demux_push = 0001, 0010, 0100, 1000, each one cycle after its pop; demux_data_out matches the word; counts = 1 each.
3. 7 words to dest 0 with dest_pop=0 -> 6 pushes; pause[0]=1 once count=6; word 7 stalls with fifo_pop=0. Pulse dest_pop[0] 4 times -> count=2, pause[0] clears, word 7 pops the next cycle.
4. Push to dest 1 and dest_pop[1]=1 in the same cycle at count=3 -> count stays 3, no error.
5. dest_pop[2]=1 with count[2]=0 -> estado=4 and error_out=1 on the next edge; further words not popped; reset recovers to RESET.
6. INIT with alto=2, bajo=3 then init=0 -> ERROR. Separately, init=1 during ACTIVE with count[0]=3 -> INIT, count preserved, pops stop; init=0 → IDLE→ACTIVE.
